// File: rtl/user_code_bank_loadable_if.sv
// Fetch and byte-serial programming port of the loadable i281 user-code bank.
// The master side is the CPU/programmer; the slave side is the bank itself.
interface user_code_bank_loadable_if #(
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 16
);
    logic [ADDR_W-1:0] fetch_addr;
    logic [WIDTH-1:0]  fetch_data;
    logic              prog_start;
    logic [7:0]        prog_byte;
    logic              prog_valid;
    logic              prog_ready;
    logic              prog_last;
    logic              busy;
    logic              prog_done;
    logic [ADDR_W:0]   word_count;

    modport master (
        output fetch_addr, prog_start, prog_byte, prog_valid, prog_last,
        input  fetch_data, prog_ready, busy, prog_done, word_count
    );

    modport slave (
        input  fetch_addr, prog_start, prog_byte, prog_valid, prog_last,
        output fetch_data, prog_ready, busy, prog_done, word_count
    );
endinterface

// File: rtl/user_code_bank_loadable.sv
// Run-time loadable DEPTH x WIDTH instruction bank for the i281 CPU.
// Words arrive MSB-first as bytes; fetch reads are combinational and blanked while busy.
module user_code_bank_loadable #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
) (
    input logic clk,
    input logic rst,
    user_code_bank_loadable_if.slave bus
);
    localparam int NBYTES = WIDTH / 8;
    localparam int BI_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BI_W-1:0]   LAST_BI   = BI_W'(NBYTES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FETCH_LIM = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BI_W-1:0]   byte_idx_q, byte_idx_d;
    logic [WIDTH-1:0]  asm_q, asm_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              we;
    logic              xfer;
    logic [WIDTH-1:0]  wdata;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    assign xfer  = bus.prog_valid & ready_q;
    // Shifting the whole word keeps WIDTH == 8 legal: older bytes simply fall off the top.
    assign wdata = (asm_q << 8) | WIDTH'(bus.prog_byte);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        byte_idx_d   = byte_idx_q;
        asm_d        = asm_q;
        word_count_d = word_count_q;
        we           = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.prog_start) begin
                    state_d      = LOAD;
                    addr_d       = '0;
                    byte_idx_d   = '0;
                    asm_d        = '0;
                    word_count_d = '0;
                end
            end
            LOAD: begin
                if (xfer) begin
                    if (byte_idx_q != LAST_BI) begin
                        asm_d      = wdata;
                        byte_idx_d = byte_idx_q + 1'b1;
                    end else begin
                        we           = 1'b1;
                        byte_idx_d   = '0;
                        word_count_d = {1'b0, addr_q} + 1'b1;
                        if (bus.prog_last || addr_q == LAST_ADDR) state_d = DONE;
                        else addr_d = addr_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == LOAD);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            byte_idx_q   <= '0;
            asm_q        <= '0;
            word_count_q <= '0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b0;
            done_q       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            byte_idx_q   <= byte_idx_d;
            asm_q        <= asm_d;
            word_count_q <= word_count_d;
            busy_q       <= busy_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
            if (we) mem_q[addr_q] <= wdata;
        end
    end

    // Addresses beyond DEPTH and any fetch during a load read as NOOP.
    always_comb begin
        bus.fetch_data = '0;
        if (!busy_q && ({1'b0, bus.fetch_addr} < FETCH_LIM)) bus.fetch_data = mem_q[bus.fetch_addr];
    end

    assign bus.busy       = busy_q;
    assign bus.prog_ready = ready_q;
    assign bus.prog_done  = done_q;
    assign bus.word_count = word_count_q;
endmodule

// File: tb/tb_user_code_bank_loadable.sv
// Scoreboard bench for user_code_bank_loadable: a DEPTH=16 and a DEPTH=10 instance,
// random byte streams checked against a word-array reference model.
module tb_user_code_bank_loadable;
    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic chk_req = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    user_code_bank_loadable_if #(.ADDR_W(4), .WIDTH(16)) b16 ();
    user_code_bank_loadable_if #(.ADDR_W(4), .WIDTH(16)) b10 ();

    user_code_bank_loadable #(.DEPTH(16), .WIDTH(16), .ADDR_W(4)) dut16 (
        .clk(clk), .rst(rst), .bus(b16.slave));
    user_code_bank_loadable #(.DEPTH(10), .WIDTH(16), .ADDR_W(4)) dut10 (
        .clk(clk), .rst(rst), .bus(b10.slave));

    typedef struct {
        int          sel;
        logic [15:0] data;
        logic        busy;
        logic        ready;
    } fchk_t;

    fchk_t       fq[$];
    int          dq16[$];
    int          dq10[$];
    logic [15:0] ref16 [16];
    logic [15:0] ref10 [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event seen/missing, expected otherwise", nm);
    endtask

    // Monitor: pops expectations whenever the DUT presents a fetch result or a done pulse.
    always @(negedge clk) begin
        fchk_t c;
        int    w;
        if (chk_req) begin
            if (fq.size() == 0) fail_now("fetch_queue_underflow");
            else begin
                c = fq.pop_front();
                if (c.sel == 0) begin
                    chk("fetch_data16", 32'(b16.fetch_data), 32'(c.data));
                    chk("busy16", 32'(b16.busy), 32'(c.busy));
                    chk("ready16", 32'(b16.prog_ready), 32'(c.ready));
                end else begin
                    chk("fetch_data10", 32'(b10.fetch_data), 32'(c.data));
                    chk("busy10", 32'(b10.busy), 32'(c.busy));
                    chk("ready10", 32'(b10.prog_ready), 32'(c.ready));
                end
            end
        end
        if (b16.prog_done) begin
            if (dq16.size() == 0) fail_now("unexpected_done16");
            else begin
                w = dq16.pop_front();
                chk("word_count16", 32'(b16.word_count), 32'(w));
                chk("busy_in_done16", 32'(b16.busy), 32'd1);
            end
        end
        if (b10.prog_done) begin
            if (dq10.size() == 0) fail_now("unexpected_done10");
            else begin
                w = dq10.pop_front();
                chk("word_count10", 32'(b10.word_count), 32'(w));
                chk("busy_in_done10", 32'(b10.busy), 32'd1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input int sel, input logic st, input logic v, input logic [7:0] b, input logic l);
        if (sel == 0) begin
            b16.prog_start = st; b16.prog_valid = v; b16.prog_byte = b; b16.prog_last = l;
        end else begin
            b10.prog_start = st; b10.prog_valid = v; b10.prog_byte = b; b10.prog_last = l;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input int sel);
        drive(sel, 1'b1, 1'b0, 8'h00, 1'b0);
        idle(1);
        drive(sel, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic fetch(input int sel, input logic [3:0] a, input logic eb, input logic er);
        logic [15:0] e;
        e = '0;
        if (sel == 0) begin
            b16.fetch_addr = a;
            if (!eb) e = ref16[a];
        end else begin
            b10.fetch_addr = a;
            if (!eb && a < 4'd10) e = ref10[a];
        end
        fq.push_back('{sel, e, eb, er});
        chk_req = 1'b1;
        @(posedge clk);
        #1 chk_req = 1'b0;
    endtask

    task automatic send_byte(input int sel, input logic [7:0] b, input logic l);
        logic rdy;
        int   guard;
        rdy   = 1'b0;
        guard = 0;
        drive(sel, 1'b0, 1'b1, b, l);
        while (!rdy && guard < 64) begin
            @(negedge clk);
            rdy = (sel == 0) ? b16.prog_ready : b10.prog_ready;
            @(posedge clk);
            guard++;
        end
        #1;
        drive(sel, 1'b0, 1'b0, 8'h00, 1'b0);
        if (!rdy) fail_now("prog_ready_timeout");
    endtask

    // Reference: bytes pair into MSB-first words; a load ends on prog_last with a word's
    // second byte or when the bank is full.
    task automatic do_load(input int sel, input logic [7:0] bq[$], input logic lq[$],
                           input int stall_at, input int gap_max, input bit start_mid);
        int          depth;
        logic [15:0] wq[$];
        depth = (sel == 0) ? 16 : 10;
        for (int i = 0; i + 1 < bq.size() && wq.size() < depth; i += 2) begin
            wq.push_back({bq[i], bq[i+1]});
            if (lq[i+1]) break;
        end
        if (sel == 0) dq16.push_back(wq.size()); else dq10.push_back(wq.size());
        pulse_start(sel);
        for (int i = 0; i < 2 * wq.size(); i++) begin
            if (i == stall_at) begin
                for (int k = 0; k < 5; k++) fetch(sel, 4'($urandom_range(0, 15)), 1'b1, 1'b1);
            end else if (gap_max > 0) idle($urandom_range(0, gap_max));
            if (start_mid && i == 2) pulse_start(sel);
            send_byte(sel, bq[i], lq[i]);
        end
        idle(1);
        for (int k = 0; k < wq.size(); k++) begin
            if (sel == 0) ref16[k] = wq[k]; else ref10[k] = wq[k];
        end
    endtask

    task automatic rand_stream(input int nwords, input bit force_last,
                               output logic [7:0] bq[$], output logic lq[$]);
        bq = {};
        lq = {};
        for (int i = 0; i < 2 * nwords; i++) begin
            bq.push_back(8'($urandom));
            if (i % 2 == 0) lq.push_back(1'($urandom));
            else if (i == 2 * nwords - 1) lq.push_back(force_last ? 1'b1 : 1'($urandom));
            else lq.push_back(1'b0);
        end
    endtask

    initial begin
        logic [7:0] bq[$];
        logic       lq[$];
        int         n;
        drive(0, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 1'b0, 8'h00, 1'b0);
        b16.fetch_addr = '0;
        b10.fetch_addr = '0;
        for (int i = 0; i < 16; i++) ref16[i] = '0;
        for (int i = 0; i < 10; i++) ref10[i] = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("word_count_reset16", 32'(b16.word_count), 32'd0);
        chk("done_reset16", 32'(b16.prog_done), 32'd0);
        for (int a = 0; a < 16; a++) fetch(0, 4'(a), 1'b0, 1'b0);

        bq = '{8'hE0, 8'hF4, 8'h50, 8'h01, 8'hE0, 8'hEE};
        lq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_load(0, bq, lq, -1, 0, 1'b0);
        chk("directed_word0", 32'(ref16[0]), 32'h0000E0F4);
        for (int a = 0; a < 4; a++) fetch(0, 4'(a), 1'b0, 1'b0);

        rand_stream(4, 1'b1, bq, lq);
        do_load(0, bq, lq, 3, 0, 1'b0);
        for (int a = 0; a < 16; a++) fetch(0, 4'(a), 1'b0, 1'b0);

        rand_stream(16, 1'b0, bq, lq);
        lq[31] = 1'b0;
        do_load(0, bq, lq, -1, 1, 1'b0);
        drive(0, 1'b0, 1'b1, 8'hA5, 1'b0);
        for (int k = 0; k < 3; k++) fetch(0, 4'(k + 13), 1'b0, 1'b0);
        drive(0, 1'b0, 1'b0, 8'h00, 1'b0);

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 16);
            rand_stream(n, (n < 16), bq, lq);
            do_load(0, bq, lq, -1, 2, 1'b0);
            for (int k = 0; k < 6; k++) fetch(0, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
        end

        pulse_start(0);
        send_byte(0, 8'h12, 1'b0);
        send_byte(0, 8'h34, 1'b0);
        send_byte(0, 8'h56, 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) ref16[i] = '0;
        for (int i = 0; i < 10; i++) ref10[i] = '0;
        chk("word_count_after_abort", 32'(b16.word_count), 32'd0);
        for (int a = 0; a < 16; a++) fetch(0, 4'(a), 1'b0, 1'b0);

        rand_stream(4, 1'b1, bq, lq);
        do_load(1, bq, lq, -1, 1, 1'b1);
        for (int a = 0; a < 16; a++) fetch(1, 4'(a), 1'b0, 1'b0);
        rand_stream(10, 1'b0, bq, lq);
        lq[19] = 1'b0;
        do_load(1, bq, lq, -1, 0, 1'b0);
        fetch(1, 4'd12, 1'b0, 1'b0);
        for (int a = 0; a < 10; a++) fetch(1, 4'(a), 1'b0, 1'b0);

        idle(2);
        chk("pending_done16", 32'(dq16.size()), 32'd0);
        chk("pending_done10", 32'(dq10.size()), 32'd0);
        chk("pending_fetch", 32'(fq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
